ss_step_ctrl: RTL
=================

# ss_step_ctrl

Sequencer that drives one `vect_mul` instance to advance the state-space recurrence x[k+1] = A·x[k] + B·u[k]. It issues the `clr`/`en` handshake and monitors `ready`, and it muxes the matrix and vector operands between the A/x and B/u passes. It also captures each pass result and writes the saturated sum back into the state register. It sits between the top-level step scheduler (start/done) and the multiplier datapath.

## Interface
Parameters:
- `WIDTH`, 43, signed fixed-point width of state, input and matrix entries
- `FRAC`, 32, fractional bits; `vect_mul` is instantiated externally with the same WIDTH/FRAC for matrix and vector
- `N_MAX`, taken from the shared `N_MAX` define; not overridable per instance

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `load`  in  1  while in IDLE, write `x_in` into the state register
- `x_in`  in  N_MAX*WIDTH  initial state value
- `start`  in  1  request one step; accepted only in IDLE
- `u`  in  N_MAX*WIDTH  input vector; sampled on accept
- `N_config`  in  8  active dimension; sampled on accept
- `mat_a`, `mat_b`  in  N_MAX*N_MAX*WIDTH  A and B, packed row-major with the same layout as the multiplier `mat` port
- `mul_mat`  out  N_MAX*N_MAX*WIDTH  to multiplier `mat`
- `mul_vect`  out  N_MAX*WIDTH  to multiplier `vect`
- `mul_n`  out  8  to multiplier `N_config` (latched value)
- `mul_en`, `mul_clr`  out  1  multiplier control
- `mul_ready`  in  1  multiplier `ready`
- `mul_out`  in  N_MAX*WIDTH  multiplier result
- `x`  out  N_MAX*WIDTH  current state register
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse, registered
- `err`  out  1  one-cycle pulse on a rejected start

## Operation
- FSM states: IDLE → CLR_A → RUN_A → CLR_B → RUN_B → IDLE.
- IDLE
  - `load` has priority over `start`. On `load`, x ← `x_in` and `start` is ignored.
  - On `start`, if `N_config` == 0 or `N_config` > N_MAX: `err` pulses next cycle and the FSM stays in IDLE.
  - Otherwise latch `u` and `N_config`, then go to CLR_A.
- CLR_A: `mul_clr`=1 for exactly one cycle; operands are A and x.
- RUN_A
  - `mul_clr`=0; wait for `mul_ready`.
  - On `mul_ready`, acc ← `mul_out`, then go to CLR_B.
  - `mul_ready` is sampled only in RUN_A and RUN_B. The multiplier's idle-high `ready` is ignored elsewhere.
- CLR_B / RUN_B: same handshake with operands B and latched u.
  - On `mul_ready`, x[i] ← sat(acc[i] + mul_out[i]) for i < N, and x[i] ← 0 for i ≥ N.
  - `done` pulses next cycle.
- `mul_en` = `busy`.
- `mul_mat`/`mul_vect` select A/x during CLR_A/RUN_A and B/u during CLR_B/RUN_B. In IDLE they select A/x.
- Arithmetic: each addition is widened to WIDTH+1 bits, then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- `x` changes only on load, on RUN_B completion, or on reset.

## Timing
- Reset values: state=IDLE; x, acc, latched u/N = 0; `busy`, `done`, `err`, `mul_clr`, `mul_en` = 0.
- `rst` asserted mid-step aborts to IDLE on the next edge with no `done` pulse.
- Step timeline, with start sampled in cycle 0 and N = `N_config`:
  - CLR_A in cycle 1
  - `mul_ready` seen in cycle 2+N
  - CLR_B in cycle 3+N
  - `mul_ready` seen in cycle 4+2N
  - `done`=1 in cycle 5+2N, with the new `x` visible in the same cycle; `busy` is 0 in that cycle
- A `start` in the `done` cycle is accepted, allowing back-to-back steps.
- `start` while `busy` is ignored, with no `err`.
- Changes to `u` or `N_config` during a step have no effect.

## Structure
- Shared package/defines: `N_MAX`, the FSM state encoding, and the signed saturate helper, which is reused by later state-space blocks.
- One sub-module: `sat_add`, a WIDTH-bit signed saturating adder. It is instantiated N_MAX times in a generate loop.
- The bench pairs this block with a real `vect_mul` (and `mac`) instance, not a model.

## Test plan
- Identity step, 1.0 = 2^32: load x=[1.0, 2.0]; start with N=2, A=B=I, u=[0.5, −1.0].
  - Required: x=[1.5, 1.0] and `done` in cycle 9.
  - Required: `mul_clr` high only in cycles 1 and 5.
- Saturation: N=1, A=B=[1.0], x=[2^(WIDTH−1)−1 LSB], u=[1.0] → x = 2^(WIDTH−1)−1 exactly, with no wrap.
- Rejects: start with N=0 → `err` pulse and x unchanged. Start with N=N_MAX+1 → same result.
- Priority: `load` and `start` in the same cycle → x = `x_in`, `busy` stays 0, no `done`.
- Abort: `rst` in RUN_B.
  - Required: IDLE next cycle, x=0, and no `done`.
  - A following start with N=2 completes in 9 cycles.
- Back-to-back: start held continuously for 3 steps with N=3, A=0.5·I, B=0, x=[4.0, 4.0, 4.0].
  - Required: x=[0.5, 0.5, 0.5] after the 3rd `done`; `done` at cycles 11, 22, 33.

Source files
------------

// File: rtl/ss_step_ctrl_pkg.sv
// Shared definitions for the state-space step blocks:
// dimension limit, step FSM encoding, saturation helper.
`ifndef N_MAX
`define N_MAX 4
`endif

package ss_step_ctrl_pkg;

  localparam int N_MAX = `N_MAX;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_A,
    ST_RUN_A,
    ST_CLR_B,
    ST_RUN_B
  } step_state_t;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_kind_t;

  // top = {sign of widened sum, msb of truncated sum}
  function automatic sat_kind_t sat_kind(
    input logic [1:0] top
  );
    sat_kind_t k;
    k = SAT_NONE;
    if (top == 2'b01) begin
      k = SAT_POS;
    end else if (top == 2'b10) begin
      k = SAT_NEG;
    end
    return k;
  endfunction

endpackage

// File: rtl/mac.sv
// Fixed-point multiply-accumulate lane: y = c + (a*b >> FRAC).
module mac #(
  parameter int WIDTH = 43,
  parameter int FRAC  = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] prod;

  assign prod = PW'($signed(a)) * PW'($signed(b));
  assign y    = c + WIDTH'(prod >>> FRAC);

endmodule

// File: rtl/ss_step_ctrl_sat_add.sv
// Signed saturating adder, widened by one bit then clamped.
module sat_add
  import ss_step_ctrl_pkg::*;
#(
  parameter int WIDTH = 43
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] sum;

  assign sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  always_comb begin
    unique case (sat_kind(sum[WIDTH -: 2]))
      SAT_POS: y = {1'b0, {(WIDTH-1){1'b1}}};
      SAT_NEG: y = {1'b1, {(WIDTH-1){1'b0}}};
      default: y = sum[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/vect_mul.sv
// Matrix-vector multiplier, one column per enabled cycle;
// ready idles high and drops on clr until N columns are done.
module vect_mul
  import ss_step_ctrl_pkg::*;
#(
  parameter int WIDTH = 43,
  parameter int FRAC  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           en,
  input  logic [7:0]                     N_config,
  input  logic [N_MAX*N_MAX*WIDTH-1:0]   mat,
  input  logic [N_MAX*WIDTH-1:0]         vect,
  output logic                           ready,
  output logic [N_MAX*WIDTH-1:0]         out
);

  logic [7:0]               col;
  logic [7:0]               cj;
  logic [WIDTH-1:0]         vj;
  logic [N_MAX*WIDTH-1:0]   acc_n;

  assign cj = (col < 8'(N_MAX)) ? col : 8'd0;
  assign vj = vect[int'(cj)*WIDTH +: WIDTH];

  for (genvar i = 0; i < N_MAX; i++) begin : g_row
    mac #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_mac (
      .a (mat[(i*N_MAX + int'(cj))*WIDTH +: WIDTH]),
      .b (vj),
      .c (out[i*WIDTH +: WIDTH]),
      .y (acc_n[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col   <= '0;
      out   <= '0;
      ready <= 1'b1;
    end else if (clr) begin
      col   <= '0;
      out   <= '0;
      ready <= 1'b0;
    end else if (en && !ready) begin
      out   <= acc_n;
      col   <= col + 8'd1;
      ready <= (col + 8'd1 >= N_config);
    end
  end

endmodule

// File: rtl/ss_step_ctrl.sv
// Sequences one vect_mul through the A*x and B*u passes
// and writes the saturated sum back into the state x.
module ss_step_ctrl
  import ss_step_ctrl_pkg::*;
#(
  parameter int WIDTH = 43,
  parameter int FRAC  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [N_MAX*WIDTH-1:0]       x_in,
  input  logic                         start,
  input  logic [N_MAX*WIDTH-1:0]       u,
  input  logic [7:0]                   N_config,
  input  logic [N_MAX*N_MAX*WIDTH-1:0] mat_a,
  input  logic [N_MAX*N_MAX*WIDTH-1:0] mat_b,
  output logic [N_MAX*N_MAX*WIDTH-1:0] mul_mat,
  output logic [N_MAX*WIDTH-1:0]       mul_vect,
  output logic [7:0]                   mul_n,
  output logic                         mul_en,
  output logic                         mul_clr,
  input  logic                         mul_ready,
  input  logic [N_MAX*WIDTH-1:0]       mul_out,
  output logic [N_MAX*WIDTH-1:0]       x,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  if (FRAC >= WIDTH) begin : g_frac_chk
    $error("FRAC must be smaller than WIDTH");
  end

  step_state_t            state;
  step_state_t            state_n;
  logic [N_MAX*WIDTH-1:0] acc;
  logic [N_MAX*WIDTH-1:0] u_l;
  logic [N_MAX*WIDTH-1:0] x_new;
  logic [7:0]             n_l;
  logic                   bad_n;
  logic                   accept;
  logic                   reject;
  logic                   x_load;
  logic                   acc_cap;
  logic                   step_end;
  logic                   sel_b;

  assign bad_n = (N_config == 8'd0) ||
                 (N_config > 8'(N_MAX));

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    reject   = 1'b0;
    x_load   = 1'b0;
    acc_cap  = 1'b0;
    step_end = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load) begin
          x_load = 1'b1;
        end else if (start) begin
          if (bad_n) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = ST_CLR_A;
          end
        end
      end
      ST_CLR_A: state_n = ST_RUN_A;
      ST_RUN_A: begin
        if (mul_ready) begin
          acc_cap = 1'b1;
          state_n = ST_CLR_B;
        end
      end
      ST_CLR_B: state_n = ST_RUN_B;
      ST_RUN_B: begin
        if (mul_ready) begin
          step_end = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      x     <= '0;
      acc   <= '0;
      u_l   <= '0;
      n_l   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      done  <= step_end;
      err   <= reject;
      if (x_load) begin
        x <= x_in;
      end else if (step_end) begin
        x <= x_new;
      end
      if (accept) begin
        u_l <= u;
        n_l <= N_config;
      end
      if (acc_cap) begin
        acc <= mul_out;
      end
    end
  end

  // lanes beyond the active dimension are cleared
  for (genvar i = 0; i < N_MAX; i++) begin : g_lane
    logic [WIDTH-1:0] sum;

    sat_add #(
      .WIDTH (WIDTH)
    ) u_add (
      .a (acc[i*WIDTH +: WIDTH]),
      .b (mul_out[i*WIDTH +: WIDTH]),
      .y (sum)
    );

    assign x_new[i*WIDTH +: WIDTH] =
      (8'(i) < n_l) ? sum : '0;
  end

  assign busy     = (state != ST_IDLE);
  assign mul_en   = busy;
  assign mul_clr  = (state == ST_CLR_A) ||
                    (state == ST_CLR_B);
  assign sel_b    = (state == ST_CLR_B) ||
                    (state == ST_RUN_B);
  assign mul_mat  = sel_b ? mat_b : mat_a;
  assign mul_vect = sel_b ? u_l : x;
  assign mul_n    = n_l;

endmodule
